fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: PC_STEP, default 4, byte increment applied to the PC after each accepted memory request.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: pc_current  input  32  current PC, driven from the program_counter register output.
REQ-005 SHALL have port: pc_next  output  32  next PC, driving the program_counter register input; combinational.
REQ-006 SHALL have port: redirect_valid  input  1  branch/jump/trap redirect request.
REQ-007 SHALL have port: redirect_pc  input  32  redirect target.
REQ-008 SHALL have port: imem_req_valid  output  1  instruction memory request valid.
REQ-009 SHALL have port: imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 SHALL have port: imem_req_addr  output  32  request address.
REQ-011 SHALL have port: imem_resp_valid  input  1  response data valid; at most one per accepted request, 1+ cycles after acceptance.
REQ-012 SHALL have port: imem_resp_data  input  32  fetched instruction word.
REQ-013 SHALL have port: out_valid  output  1  fetched instruction valid to decode.
REQ-014 SHALL have port: out_ready  input  1  decode accepts instruction.
REQ-015 SHALL have port: out_pc  output  32  PC of the presented instruction.
REQ-016 SHALL have port: out_instr  output  32  presented instruction word.

Function
REQ-017 SHALL implement states FETCH, WAIT, FULL, KILL; at most one memory request outstanding.
REQ-018 FETCH: imem_req_valid=1, imem_req_addr=pc_current; on valid&ready, SHALL latch req_pc=pc_current and go to WAIT.
REQ-019 WAIT: imem_req_valid=0; on imem_resp_valid, SHALL capture out_pc=req_pc, out_instr=imem_resp_data and go to FULL.
REQ-020 FULL: out_valid=1, out_pc/out_instr held stable; on out_ready, SHALL go to FETCH (no request issued in the handshake cycle).
REQ-021 KILL: imem_req_valid=0; on imem_resp_valid, response SHALL be discarded and state SHALL go to FETCH.
REQ-022 pc_next SHALL equal pc_current except: redirect_valid -> redirect_pc; else FETCH with req handshake -> pc_current+PC_STEP (32-bit wrap, 0xFFFFFFFC+4=0x00000000).
REQ-023 Redirect SHALL have priority over every other event in the same cycle.
REQ-024 Redirect in FETCH with req handshake same cycle: pc_next=redirect_pc, state -> KILL.
REQ-025 Redirect in FETCH without handshake: the request SHALL be withdrawn/readdressed next cycle (imem protocol permits this), state stays FETCH.
REQ-026 Redirect in WAIT: without resp -> KILL; with resp same cycle -> resp discarded, state -> FETCH.
REQ-027 Redirect in FULL: out_valid SHALL drop next cycle (instruction flushed even if out_ready=1), state -> FETCH.
REQ-028 Redirect in KILL: stays KILL (or FETCH if resp same cycle); pc_next=redirect_pc.
REQ-029 imem_resp_valid in FETCH or FULL SHALL be ignored (protocol violation, no state change).
REQ-030 out_valid SHALL be 1 only in FULL.

Reset
REQ-031 On rst_n=0, asynchronously: state=FETCH, out_valid=0, out_pc=0, out_instr=0, req_pc=0; pc_next then follows REQ-022.
REQ-032 Reset mid-request SHALL abandon the outstanding request; a response arriving after rst_n release in FETCH SHALL be ignored per REQ-029.

Verification
REQ-033 Reset then pc_current=0, imem_req_ready=1 -> req addr 0x0, pc_next=0x4; resp 0x00500093 two cycles later -> out_valid=1, out_pc=0x0, out_instr=0x00500093.
REQ-034 out_ready=0 for 5 cycles in FULL -> out_valid, out_pc, out_instr stable, imem_req_valid=0, pc_next=pc_current.
REQ-035 Redirect to 0x100 in the cycle FETCH handshakes at 0x8 -> pc_next=0x100, following resp for 0x8 dropped, next request addr 0x100.
REQ-036 Redirect to 0x200 in FULL with out_ready=1 -> no out handshake counted, out_valid=0 next cycle, next request addr 0x200.
REQ-037 imem_req_ready=0 for 3 cycles at pc 0x40 -> req_valid held, addr 0x40, pc_next=0x40; accept -> pc_next=0x44.
REQ-038 pc_current=0xFFFFFFFC, handshake -> pc_next=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a single-entry output
// buffer to decode, and redirect handling that squashes in-flight fetches.
module fetch_unit #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_FULL,
    ST_KILL
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_out_valid;
  logic        w_req_fire;

  assign w_req_fire     = (r_state == ST_FETCH) && imem_req_ready;
  assign imem_req_valid = (r_state == ST_FETCH);
  assign imem_req_addr  = pc_current;
  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_instr      = r_out_instr;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pc_next = pc_current;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (w_req_fire) begin
      pc_next = pc_current + PC_INC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FETCH;
      r_req_pc    <= '0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          // A redirect without a handshake needs no action: the address follows pc_current.
          if (w_req_fire) begin
            r_req_pc <= pc_current;
            r_state  <= redirect_valid ? ST_KILL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            r_state <= imem_resp_valid ? ST_FETCH : ST_KILL;
          end else if (imem_resp_valid) begin
            r_out_pc    <= r_req_pc;
            r_out_instr <= imem_resp_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A redirect flushes the buffered instruction even if decode is taking it.
          if (redirect_valid || out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_FETCH;
          end
        end
        ST_KILL: begin
          if (imem_resp_valid) begin
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: pc_current is driven directly by the stimulus,
// with every expected value worked out by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.PC_STEP(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_current      (pc_current),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic [31:0] pc, input logic rdy, input logic rsp_v,
                       input logic [31:0] rsp_d, input logic ordy,
                       input logic redir_v, input logic [31:0] redir_pc);
    pc_current      = pc;
    imem_req_ready  = rdy;
    imem_resp_valid = rsp_v;
    imem_resp_data  = rsp_d;
    out_ready       = ordy;
    redirect_valid  = redir_v;
    redirect_pc     = redir_pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    rst_n = 1'b1;

    // First fetch from 0x0, response two cycles after acceptance
    drive(32'h0, 1, 0, 32'h0, 0, 0, 32'h0);
    check("f0_req_valid", 32'(imem_req_valid), 32'd1);
    check("f0_req_addr", imem_req_addr, 32'h0);
    check("f0_pc_next", pc_next, 32'h4);
    tick();
    drive(32'h4, 1, 0, 32'h0, 0, 0, 32'h0);
    check("f0_wait_req_valid", 32'(imem_req_valid), 32'd0);
    check("f0_wait_pc_next", pc_next, 32'h4);
    tick();
    drive(32'h4, 0, 1, 32'h0050_0093, 0, 0, 32'h0);
    check("f0_wait_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("f0_out_valid", 32'(out_valid), 32'd1);
    check("f0_out_pc", out_pc, 32'h0);
    check("f0_out_instr", out_instr, 32'h0050_0093);

    // Decode stalls for five cycles
    drive(32'h4, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_pc_next", pc_next, 32'h4);
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_pc", out_pc, 32'h0);
      check("stall_out_instr", out_instr, 32'h0050_0093);
    end
    drive(32'h4, 1, 0, 32'h0, 1, 0, 32'h0);
    check("hs_req_valid", 32'(imem_req_valid), 32'd0);
    check("hs_pc_next", pc_next, 32'h4);
    tick();
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_next_req_valid", 32'(imem_req_valid), 32'd1);

    // Second fetch at 0x4
    drive(32'h4, 1, 0, 32'h0, 0, 0, 32'h0);
    check("f4_pc_next", pc_next, 32'h8);
    tick();
    drive(32'h8, 0, 1, 32'h1111_1111, 0, 0, 32'h0);
    tick();
    check("f4_out_pc", out_pc, 32'h4);
    check("f4_out_instr", out_instr, 32'h1111_1111);
    drive(32'h8, 0, 0, 32'h0, 1, 0, 32'h0);
    tick();

    // Redirect in the same cycle as the handshake at 0x8
    drive(32'h8, 1, 0, 32'h0, 0, 1, 32'h100);
    check("kill_req_addr", imem_req_addr, 32'h8);
    check("kill_pc_next", pc_next, 32'h100);
    tick();
    drive(32'h100, 1, 0, 32'h0, 0, 0, 32'h0);
    check("kill_req_valid", 32'(imem_req_valid), 32'd0);
    check("kill_pc_next_hold", pc_next, 32'h100);
    tick();
    drive(32'h100, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    tick();
    check("kill_drop_out_valid", 32'(out_valid), 32'd0);
    check("kill_after_req_valid", 32'(imem_req_valid), 32'd1);
    check("kill_after_req_addr", imem_req_addr, 32'h100);
    drive(32'h100, 1, 0, 32'h0, 0, 0, 32'h0);
    check("f100_pc_next", pc_next, 32'h104);
    tick();
    drive(32'h104, 0, 1, 32'h2222_2222, 0, 0, 32'h0);
    tick();
    check("f100_out_valid", 32'(out_valid), 32'd1);
    check("f100_out_pc", out_pc, 32'h100);

    // Redirect while FULL with decode ready: instruction is flushed
    drive(32'h104, 0, 0, 32'h0, 1, 1, 32'h200);
    check("full_redir_pc_next", pc_next, 32'h200);
    tick();
    check("full_redir_out_valid", 32'(out_valid), 32'd0);
    drive(32'h200, 0, 0, 32'h0, 0, 0, 32'h0);
    check("full_redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("full_redir_req_addr", imem_req_addr, 32'h200);
    check("full_redir_pc_hold", pc_next, 32'h200);

    // Redirect in FETCH without handshake, then memory back-pressure at 0x40
    drive(32'h200, 0, 0, 32'h0, 0, 1, 32'h40);
    check("fetch_redir_pc_next", pc_next, 32'h40);
    tick();
    drive(32'h40, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h40);
      check("bp_pc_next", pc_next, 32'h40);
      tick();
    end
    drive(32'h40, 1, 0, 32'h0, 0, 0, 32'h0);
    check("bp_accept_pc_next", pc_next, 32'h44);
    tick();
    check("bp_wait_req_valid", 32'(imem_req_valid), 32'd0);

    // Redirect in WAIT together with the response: response dropped
    drive(32'h44, 0, 1, 32'h3333_3333, 0, 1, 32'h80);
    check("wait_redir_pc_next", pc_next, 32'h80);
    tick();
    check("wait_redir_out_valid", 32'(out_valid), 32'd0);
    check("wait_redir_req_valid", 32'(imem_req_valid), 32'd1);

    // PC wrap at the top of the address space
    drive(32'h80, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(32'hFFFF_FFFC, 1, 0, 32'h0, 0, 0, 32'h0);
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next, 32'h0);
    tick();

    // Redirect in WAIT without response, then redirect plus response in KILL
    drive(32'h0, 0, 0, 32'h0, 0, 1, 32'h300);
    tick();
    drive(32'h300, 1, 0, 32'h0, 0, 0, 32'h0);
    check("wait_kill_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_kill_pc_next", pc_next, 32'h300);
    tick();
    drive(32'h300, 0, 1, 32'h4444_4444, 0, 1, 32'h500);
    check("kill_redir_pc_next", pc_next, 32'h500);
    tick();
    check("kill_redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("kill_redir_out_valid", 32'(out_valid), 32'd0);

    // Stray response in FETCH is ignored
    drive(32'h500, 0, 1, 32'h5555_5555, 0, 0, 32'h0);
    tick();
    check("stray_req_valid", 32'(imem_req_valid), 32'd1);
    check("stray_out_valid", 32'(out_valid), 32'd0);

    // Reset with a request outstanding; the late response must be ignored
    drive(32'h500, 1, 0, 32'h0, 0, 0, 32'h0);
    tick();
    drive(32'h504, 0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd1);
    check("midrst_out_pc", out_pc, 32'h0);
    #1;
    rst_n = 1'b1;
    drive(32'h504, 0, 1, 32'h6666_6666, 0, 0, 32'h0);
    tick();
    check("midrst_late_out_valid", 32'(out_valid), 32'd0);
    check("midrst_late_req_valid", 32'(imem_req_valid), 32'd1);
    drive(32'h504, 1, 0, 32'h0, 0, 0, 32'h0);
    check("midrst_pc_next", pc_next, 32'h508);
    tick();
    drive(32'h508, 0, 1, 32'h7777_7777, 0, 0, 32'h0);
    tick();
    check("midrst_out_pc2", out_pc, 32'h504);
    check("midrst_out_instr2", out_instr, 32'h7777_7777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
